motoro3_line_calc_seq: RTL and testbench
========================================

Name: motoro3_line_calc_seq

Overview:
- Parametrised, sequential successor of the per-step PWM line calculator.
- On a request pulse it latches the step/split position and the motor registers (power, speed, wanted length, minimum mask, split count).
- It computes the sine-weighted, power-scaled PWM length with an iterative shift-add datapath, then clamps the result to the minimum mask, the speed window and the output width.
- It sits between the motoro3 register file and the PWM generator, replacing the combinational line calculator.

Parameters:
- LEN_W, 12, width of m3r_pwmLenWant and m3r_pwmMinMask.
- PCT_W, 8, width of m3r_power_percent, in units of 1 %.
- SPD_W, 25, width of m3r_stepCNT_speedSET.
- PWM_W, 16, width of pwmLENpos (saturation limit 2^PWM_W-1).
- SIN_W, 8, sine table amplitude width (full scale 2^SIN_W-1).

Ports:
- clk  in  1  system clock.
- nRst  in  1  asynchronous active-low reset.
- calcReq  in  1  single-cycle start pulse.
- lcStep  in  4  electrical step 0..11; values 0..5 positive half, 6..11 negative half.
- m3LpwmSplitStep  in  2  sub-step inside the current step.
- m3r_stepSplitMax  in  2  split count minus 1; legal values 0, 1, 3.
- m3r_power_percent  in  PCT_W  power scale, 100 = 100 %.
- m3r_stepCNT_speedSET  in  SPD_W  step period in clk cycles.
- m3r_pwmLenWant  in  LEN_W  nominal PWM length.
- m3r_pwmMinMask  in  LEN_W  results below this value are forced to 0.
- pwmLENpos  out  PWM_W  registered result.
- slLen  out  SIN_W  registered sine weight used.
- pwmNeg  out  1  registered; 1 when lcStep >= 6.
- calcBusy  out  1  datapath occupied.
- calcVld  out  1  one-cycle pulse when all outputs update.
- calcErr  out  1  registered with calcVld; illegal step or split.
- reqDropped  out  1  sticky flag; cleared only by reset.

Behaviour:
- Reset (async, nRst low): all outputs 0, FSM to IDLE, counters 0. Reset asserted mid-calculation aborts the calculation; no calcVld follows.
- FSM states: IDLE -> MUL1 -> MUL2 -> SCALE -> CLAMP -> DONE -> IDLE.
- IDLE: calcReq=1 in cycle N latches every input into shadow registers. Inputs are don't-care after cycle N.
- MUL1: cycles N+1..N+SIN_W. Shift-add of the latched lenWant by the sine weight, 1 bit per cycle, LSB first.
- MUL2: next PCT_W cycles. Multiplies the MUL1 product by power, same shift-add scheme.
- SCALE: 1 cycle. prod = prod*41 >> 20 (41/4096 approximates /100; >>8 removes sine scaling).
- CLAMP: 1 cycle.
  - If the result < pwmMinMask, the result is 0.
  - Otherwise, if the result > speedSET-1, the result is speedSET-1. If speedSET = 0, the result is 0.
  - The result then saturates to 2^PWM_W-1.
- DONE: outputs are registered and calcVld=1 in cycle N+SIN_W+PCT_W+3, which is N+19 at defaults.
- Outputs hold their values until the next DONE.
- calcBusy is 1 from cycle N+1 through the DONE cycle inclusive.
- A new calcReq is accepted in the first IDLE cycle after DONE.
- calcReq while busy, including in the DONE cycle: the request is ignored, reqDropped is set and the calculation in flight is unaffected.
- Sine table: sin_q[k] = round((2^SIN_W-1)*sin(pi*(k+0.5)/24)), k = 0..23.
- Index: S = stepSplitMax+1; k = (lcStep mod 6)*4 + splitStep*(4/S).
- Illegal combination (lcStep > 11, stepSplitMax = 2, or splitStep > stepSplitMax):
  - The FSM runs the normal latency.
  - pwmLENpos = 0, slLen = 0, calcErr = 1.
- Intermediate widths: MUL1 LEN_W+SIN_W bits; MUL2 LEN_W+SIN_W+PCT_W bits; SCALE +6 bits. No truncation occurs before the >>20.

Decomposition:
- Shared package motoro3_pkg holds:
  - FSM state enum;
  - constants STEP_PER_HALF=6, SPLIT_NORM=4, SIN_ENTRIES=24, PCT_RECIP=41, PCT_SHIFT=12;
  - function computing the latency.
- Sub-module motoro3_sine_rom: combinational 24-entry ROM, parametrised by SIN_W, with index-legality output.
- Top level: FSM, shift-add datapath and clamp.

Test Plan:
- Nominal case: lenWant=1000, power=100, lcStep=2, split=3 of max 3 (k=11, sine=254), speed=100000, minMask=0 -> calcVld at N+19, pwmLENpos=993, slLen=254, pwmNeg=0.
- Negative half: lcStep=6, max=0, split=0 (k=0, sine=17), lenWant=4095, power=255 -> pwmLENpos=((4095*17*255*41)>>20)=694, pwmNeg=1.
- Clamps:
  - nominal case with minMask=994 -> 0;
  - nominal case with speed=500 -> 499;
  - nominal case with speed=0 -> 0.
- Illegal index: stepSplitMax=2, or lcStep=12 -> calcErr=1, pwmLENpos=0, and latency still 19.
- Back-to-back requests:
  - calcReq at N+5 and at N+19 -> both ignored, reqDropped=1, first result intact;
  - calcReq at N+20 -> accepted, valid at N+39.
- Reset: nRst low at N+10 -> outputs 0 at once, no calcVld; reqDropped cleared; next request is computed normally.

Source files
------------

// File: rtl/motoro3_pkg.sv
// Shared types and constants for the motoro3 sequential line calculator.
package motoro3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL1  = 3'd1,
    ST_MUL2  = 3'd2,
    ST_SCALE = 3'd3,
    ST_CLAMP = 3'd4,
    ST_DONE  = 3'd5
  } calc_state_e;

  localparam int STEP_PER_HALF = 6;
  localparam int SPLIT_NORM    = 4;
  localparam int SIN_ENTRIES   = 24;
  localparam int PCT_RECIP     = 41;
  localparam int PCT_SHIFT     = 12;

  // Request-to-valid distance in cycles: one cycle per multiplier bit plus SCALE, CLAMP, DONE.
  function automatic int calc_latency(input int sin_w, input int pct_w);
    return sin_w + pct_w + 3;
  endfunction

endpackage

// File: rtl/motoro3_sine_rom.sv
// Half-wave sine weight ROM (24 entries, mirrored around the peak) with index legality check.
// Purely combinational; no flow control.
module motoro3_sine_rom
  import motoro3_pkg::*;
#(
  parameter int SIN_W = 8
) (
  input  logic [3:0]       i_step,
  input  logic [1:0]       i_split,
  input  logic [1:0]       i_split_max,
  output logic [SIN_W-1:0] o_sine,
  output logic             o_legal
);

  logic [3:0] w_half;
  logic [5:0] w_ofs;
  logic [5:0] w_k;
  logic [5:0] w_kf;
  logic [7:0] w_q8;

  always_comb begin
    w_half = (i_step >= 4'(STEP_PER_HALF)) ? i_step - 4'(STEP_PER_HALF) : i_step;
    case (i_split_max)
      2'd0:    w_ofs = 6'(i_split) * 6'(SPLIT_NORM);
      2'd1:    w_ofs = 6'(i_split) * 6'(SPLIT_NORM / 2);
      default: w_ofs = 6'(i_split);
    endcase
    w_k     = 6'(w_half) * 6'(SPLIT_NORM) + w_ofs;
    o_legal = (i_step < 4'(2 * STEP_PER_HALF)) && (i_split_max != 2'd2) &&
              (i_split <= i_split_max);
    // Second quarter mirrors the first; only 12 distinct values are stored.
    w_kf = (w_k >= 6'(SIN_ENTRIES / 2)) ? 6'(SIN_ENTRIES - 1) - w_k : w_k;
    case (w_kf)
      6'd0:    w_q8 = 8'd17;
      6'd1:    w_q8 = 8'd50;
      6'd2:    w_q8 = 8'd82;
      6'd3:    w_q8 = 8'd113;
      6'd4:    w_q8 = 8'd142;
      6'd5:    w_q8 = 8'd168;
      6'd6:    w_q8 = 8'd192;
      6'd7:    w_q8 = 8'd212;
      6'd8:    w_q8 = 8'd229;
      6'd9:    w_q8 = 8'd241;
      6'd10:   w_q8 = 8'd250;
      6'd11:   w_q8 = 8'd254;
      default: w_q8 = 8'd0;
    endcase
    // Table is stored at 8-bit full scale; rescale with rounding to SIN_W.
    o_sine = o_legal ?
             SIN_W'((32'(w_q8) * ((32'd1 << SIN_W) - 32'd1) + 32'd127) / 32'd255) : '0;
  end

endmodule

// File: rtl/motoro3_line_calc_seq.sv
// Sequential sine-weighted, power-scaled PWM length calculator with min/speed/width clamping.
// Result valid SIN_W+PCT_W+3 cycles after calcReq; requests while busy are dropped and flagged.
module motoro3_line_calc_seq
  import motoro3_pkg::*;
#(
  parameter int LEN_W = 12,
  parameter int PCT_W = 8,
  parameter int SPD_W = 25,
  parameter int PWM_W = 16,
  parameter int SIN_W = 8
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             calcReq,
  input  logic [3:0]       lcStep,
  input  logic [1:0]       m3LpwmSplitStep,
  input  logic [1:0]       m3r_stepSplitMax,
  input  logic [PCT_W-1:0] m3r_power_percent,
  input  logic [SPD_W-1:0] m3r_stepCNT_speedSET,
  input  logic [LEN_W-1:0] m3r_pwmLenWant,
  input  logic [LEN_W-1:0] m3r_pwmMinMask,
  output logic [PWM_W-1:0] pwmLENpos,
  output logic [SIN_W-1:0] slLen,
  output logic             pwmNeg,
  output logic             calcBusy,
  output logic             calcVld,
  output logic             calcErr,
  output logic             reqDropped
);

  localparam int ACC_W = LEN_W + SIN_W + PCT_W + 6;
  localparam int RES_W = ACC_W - PCT_SHIFT - SIN_W;
  localparam int MPL_W = (SIN_W > PCT_W) ? SIN_W : PCT_W;
  localparam int CNT_W = $clog2(MPL_W + 1);
  localparam int CMP_A = (RES_W > SPD_W) ? RES_W : SPD_W;
  localparam int CMP_B = (CMP_A > PWM_W) ? CMP_A : PWM_W;
  localparam int CMP_W = ((CMP_B > LEN_W) ? CMP_B : LEN_W) + 1;

  calc_state_e r_state;
  calc_state_e w_state_nxt;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_mcand;
  logic [MPL_W-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic [PCT_W-1:0] r_pwr;
  logic [SPD_W-1:0] r_spd;
  logic [LEN_W-1:0] r_mask;
  logic [SIN_W-1:0] r_sin;
  logic             r_neg;
  logic             r_err;

  logic [SIN_W-1:0] w_rom_sine;
  logic             w_rom_legal;
  logic [ACC_W-1:0] w_acc_sum;
  logic [CMP_W-1:0] w_res;
  logic [CMP_W-1:0] w_spd_m1;
  logic [CMP_W-1:0] w_clamped;
  logic [PWM_W-1:0] w_pwm;

  motoro3_sine_rom #(
    .SIN_W (SIN_W)
  ) u_sine_rom (
    .i_step      (lcStep),
    .i_split     (m3LpwmSplitStep),
    .i_split_max (m3r_stepSplitMax),
    .o_sine      (w_rom_sine),
    .o_legal     (w_rom_legal)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (calcReq) w_state_nxt = ST_MUL1;
      ST_MUL1:  if (r_cnt == CNT_W'(SIN_W - 1)) w_state_nxt = ST_MUL2;
      ST_MUL2:  if (r_cnt == CNT_W'(PCT_W - 1)) w_state_nxt = ST_SCALE;
      ST_SCALE: w_state_nxt = ST_CLAMP;
      ST_CLAMP: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    calcBusy = (r_state != ST_IDLE);
    calcVld  = (r_state == ST_DONE);
  end

  assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_pwr    <= '0;
      r_spd    <= '0;
      r_mask   <= '0;
      r_sin    <= '0;
      r_neg    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (calcReq) begin
            r_acc    <= '0;
            r_mcand  <= ACC_W'(m3r_pwmLenWant);
            r_mplier <= MPL_W'(w_rom_sine);
            r_cnt    <= '0;
            r_pwr    <= m3r_power_percent;
            r_spd    <= m3r_stepCNT_speedSET;
            r_mask   <= m3r_pwmMinMask;
            r_sin    <= w_rom_sine;
            r_neg    <= (lcStep >= 4'(STEP_PER_HALF));
            r_err    <= !w_rom_legal;
          end
        end
        ST_MUL1: begin
          if (r_cnt == CNT_W'(SIN_W - 1)) begin
            // Product of the first pass becomes the multiplicand of the second.
            r_acc    <= '0;
            r_mcand  <= w_acc_sum;
            r_mplier <= MPL_W'(r_pwr);
            r_cnt    <= '0;
          end else begin
            r_acc    <= w_acc_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
          end
        end
        ST_MUL2: begin
          r_acc    <= w_acc_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
        end
        ST_SCALE: r_acc <= r_acc * ACC_W'(PCT_RECIP);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_res     = CMP_W'(r_acc >> (PCT_SHIFT + SIN_W));
    w_spd_m1  = CMP_W'(r_spd) - CMP_W'(1);
    w_clamped = w_res;
    if (w_res < CMP_W'(r_mask))    w_clamped = '0;
    else if (r_spd == '0)          w_clamped = '0;
    else if (w_res > w_spd_m1)     w_clamped = w_spd_m1;
    if (w_clamped > CMP_W'({PWM_W{1'b1}})) w_pwm = '1;
    else                                   w_pwm = PWM_W'(w_clamped);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pwmLENpos  <= '0;
      slLen      <= '0;
      pwmNeg     <= 1'b0;
      calcErr    <= 1'b0;
      reqDropped <= 1'b0;
    end else begin
      if (r_state == ST_CLAMP) begin
        pwmLENpos <= r_err ? '0 : w_pwm;
        slLen     <= r_err ? '0 : r_sin;
        pwmNeg    <= r_neg;
        calcErr   <= r_err;
      end
      if (calcReq && (r_state != ST_IDLE)) reqDropped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_motoro3_line_calc_seq.sv
// Randomized self-checking bench for motoro3_line_calc_seq against an arithmetic reference model.
module tb_motoro3_line_calc_seq;

  localparam int LAT = 19;

  logic        clk = 1'b0;
  logic        nRst;
  logic        calcReq;
  logic [3:0]  lcStep;
  logic [1:0]  m3LpwmSplitStep;
  logic [1:0]  m3r_stepSplitMax;
  logic [7:0]  m3r_power_percent;
  logic [24:0] m3r_stepCNT_speedSET;
  logic [11:0] m3r_pwmLenWant;
  logic [11:0] m3r_pwmMinMask;
  logic [15:0] pwmLENpos;
  logic [7:0]  slLen;
  logic        pwmNeg;
  logic        calcBusy;
  logic        calcVld;
  logic        calcErr;
  logic        reqDropped;

  int     n_chk = 0;
  int     n_err = 0;
  int     sin_q[24];
  bit     exp_drop = 1'b0;
  bit     pend = 1'b0;
  longint last_pwm = 0;

  always #5 clk = ~clk;

  motoro3_line_calc_seq u_dut (
    .clk                  (clk),
    .nRst                 (nRst),
    .calcReq              (calcReq),
    .lcStep               (lcStep),
    .m3LpwmSplitStep      (m3LpwmSplitStep),
    .m3r_stepSplitMax     (m3r_stepSplitMax),
    .m3r_power_percent    (m3r_power_percent),
    .m3r_stepCNT_speedSET (m3r_stepCNT_speedSET),
    .m3r_pwmLenWant       (m3r_pwmLenWant),
    .m3r_pwmMinMask       (m3r_pwmMinMask),
    .pwmLENpos            (pwmLENpos),
    .slLen                (slLen),
    .pwmNeg               (pwmNeg),
    .calcBusy             (calcBusy),
    .calcVld              (calcVld),
    .calcErr              (calcErr),
    .reqDropped           (reqDropped)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_calc(input int len, input int pwr, input int step,
                                      input int split, input int smax, input int spd,
                                      input int mask, output int sine, output bit err);
    longint p;
    err = (step > 11) || (smax == 2) || (split > smax);
    if (err) begin
      sine = 0;
      return 0;
    end
    sine = sin_q[(step % 6) * 4 + split * (4 / (smax + 1))];
    p = (longint'(len) * sine * pwr * 41) >> 20;
    if (p < mask)         p = 0;
    else if (spd == 0)    p = 0;
    else if (p > spd - 1) p = spd - 1;
    if (p > 65535) p = 65535;
    return p;
  endfunction

  task automatic scramble();
    lcStep               = 4'($urandom);
    m3LpwmSplitStep      = 2'($urandom);
    m3r_stepSplitMax     = 2'($urandom);
    m3r_power_percent    = 8'($urandom);
    m3r_stepCNT_speedSET = 25'($urandom);
    m3r_pwmLenWant       = 12'($urandom);
    m3r_pwmMinMask       = 12'($urandom);
  endtask

  // One request; drop_a/drop_b are cycle offsets (relative to N) at which an extra request is pulsed.
  task automatic do_calc(input int len, input int pwr, input int step, input int split,
                         input int smax, input int spd, input int mask,
                         input int drop_a, input int drop_b);
    int     lat;
    bit     got;
    longint e_pwm;
    int     e_sin;
    bit     e_err;
    @(negedge clk);
    exp_drop |= pend;
    pend = 1'b0;
    chk("idle_busy", calcBusy, 0);
    chk("idle_vld", calcVld, 0);
    lcStep               = 4'(step);
    m3LpwmSplitStep      = 2'(split);
    m3r_stepSplitMax     = 2'(smax);
    m3r_power_percent    = 8'(pwr);
    m3r_stepCNT_speedSET = 25'(spd);
    m3r_pwmLenWant       = 12'(len);
    m3r_pwmMinMask       = 12'(mask);
    calcReq              = 1'b1;
    e_pwm = ref_calc(len, pwr, step, split, smax, spd, mask, e_sin, e_err);
    lat = 0;
    got = 1'b0;
    while (!got && lat < LAT + 10) begin
      @(negedge clk);
      lat++;
      calcReq = 1'b0;
      scramble();
      exp_drop |= pend;
      pend = 1'b0;
      if (lat == 1) chk("busy_start", calcBusy, 1);
      if (calcVld) got = 1'b1;
      if (lat == drop_a || lat == drop_b) begin
        calcReq = 1'b1;
        pend    = 1'b1;
      end
    end
    chk("latency", got ? lat : -1, LAT);
    if (got) begin
      chk("pwmLENpos", pwmLENpos, e_pwm);
      chk("slLen", slLen, e_sin);
      chk("pwmNeg", pwmNeg, (step >= 6) ? 1 : 0);
      chk("calcErr", calcErr, e_err);
      chk("busy_done", calcBusy, 1);
      chk("reqDropped", reqDropped, exp_drop);
    end
    last_pwm = e_pwm;
  endtask

  task automatic hold_check();
    repeat (3) @(negedge clk);
    chk("hold_pwm", pwmLENpos, last_pwm);
    chk("hold_vld", calcVld, 0);
  endtask

  initial begin
    bit vld_seen;
    for (int k = 0; k < 24; k++)
      sin_q[k] = int'($floor(255.0 * $sin(3.14159265358979 * (real'(k) + 0.5) / 24.0) + 0.5));
    nRst    = 1'b0;
    calcReq = 1'b0;
    scramble();
    #1;
    chk("rst_pwm", pwmLENpos, 0);
    chk("rst_sl", slLen, 0);
    chk("rst_neg", pwmNeg, 0);
    chk("rst_busy", calcBusy, 0);
    chk("rst_vld", calcVld, 0);
    chk("rst_err", calcErr, 0);
    chk("rst_drop", reqDropped, 0);
    repeat (2) @(negedge clk);
    nRst = 1'b1;

    // Directed: nominal, negative half, clamps, illegal indices.
    do_calc(1000, 100, 2, 3, 3, 100000, 0, 0, 0);
    chk("nominal_993", pwmLENpos, 993);
    chk("nominal_254", slLen, 254);
    hold_check();
    do_calc(4095, 255, 6, 0, 0, 100000, 0, 0, 0);
    chk("neg_694", pwmLENpos, 694);
    do_calc(1000, 100, 2, 3, 3, 100000, 994, 0, 0);
    do_calc(1000, 100, 2, 3, 3, 500, 0, 0, 0);
    chk("speed_499", pwmLENpos, 499);
    do_calc(1000, 100, 2, 3, 3, 0, 0, 0, 0);
    do_calc(1000, 100, 2, 1, 2, 100000, 0, 0, 0);
    do_calc(1000, 100, 12, 0, 0, 100000, 0, 0, 0);
    hold_check();

    // Requests at N+5 and N+19 dropped; the following one at N+20 is accepted.
    do_calc(1000, 100, 2, 3, 3, 100000, 0, 5, 19);
    do_calc(2000, 50, 9, 1, 1, 100000, 0, 0, 0);
    hold_check();

    // Reset mid-calculation aborts and clears everything.
    @(negedge clk);
    lcStep = 4'd2; m3LpwmSplitStep = 2'd3; m3r_stepSplitMax = 2'd3;
    m3r_power_percent = 8'd100; m3r_stepCNT_speedSET = 25'd100000;
    m3r_pwmLenWant = 12'd1000; m3r_pwmMinMask = 12'd0;
    calcReq = 1'b1;
    repeat (10) begin
      @(negedge clk);
      calcReq = 1'b0;
    end
    nRst = 1'b0;
    #1;
    chk("abort_pwm", pwmLENpos, 0);
    chk("abort_sl", slLen, 0);
    chk("abort_neg", pwmNeg, 0);
    chk("abort_busy", calcBusy, 0);
    chk("abort_drop", reqDropped, 0);
    exp_drop = 1'b0;
    pend     = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    vld_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (calcVld) vld_seen = 1'b1;
    end
    chk("abort_no_vld", vld_seen, 0);
    do_calc(1000, 100, 2, 3, 3, 100000, 0, 0, 0);

    // Randomized requests.
    for (int t = 0; t < 40; t++) begin
      int spd;
      int mask;
      spd  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1500))
                                         : int'($urandom_range(0, 33554431));
      mask = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095))
                                         : int'($urandom_range(0, 200));
      do_calc(int'($urandom_range(0, 4095)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 13)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), spd, mask, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
